// File: rtl/bus_arbiter.sv
// Two-port round-robin arbiter and sequencer for the shared external data bus.
// Optional timeout/forced-completion path is built when BUS_ARB_TIMEOUT_EN is defined.
module bus_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              i_cpu_clk,
    input  logic              i_rst,
    input  logic              i_req0,
    input  logic              i_req1,
    input  logic              i_we0,
    input  logic              i_we1,
    input  logic [ADDR_W-1:0] i_addr0,
    input  logic [ADDR_W-1:0] i_addr1,
    input  logic [DATA_W-1:0] i_wdata0,
    input  logic [DATA_W-1:0] i_wdata1,
    output logic              o_ack0,
    output logic              o_ack1,
    output logic [DATA_W-1:0] o_rdata,
    output logic              o_err,
    output logic              o_bus_clk,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [DATA_W-1:0] o_bus_data,
    input  logic [DATA_W-1:0] i_bus_data,
    input  logic              i_bus_data_ready,
    output logic [1:0]        o_dbg_state
);

    // Handshake: a port's req is sampled only in IDLE; its we/addr/wdata must be
    // stable while req is high; completion is a single-cycle ack in the ACK state.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        ACK  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic                last_grant_q, last_grant_d;
    logic                grant_q, grant_d;
    logic                ack0_q, ack0_d;
    logic                ack1_q, ack1_d;
    logic                bus_clk_q, bus_clk_d;
    logic                bus_we_q, bus_we_d;
    logic [ADDR_W-1:0]   bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0]   bus_data_q, bus_data_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                win;

`ifdef BUS_ARB_TIMEOUT_EN
    logic [15:0]         cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                expire;

    assign expire = (cnt_q == 16'(TIMEOUT - 1));
`endif

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        grant_d      = grant_q;
        ack0_d       = 1'b0;
        ack1_d       = 1'b0;
        bus_clk_d    = bus_clk_q;
        bus_we_d     = bus_we_q;
        bus_addr_d   = bus_addr_q;
        bus_data_d   = bus_data_q;
        rdata_d      = rdata_q;
        win          = 1'b0;
`ifdef BUS_ARB_TIMEOUT_EN
        cnt_d        = cnt_q;
        err_d        = err_q;
`endif
        case (state_q)
            IDLE: begin
                if (i_req0 || i_req1) begin
                    // On a tie the port that did not win last time goes next.
                    win          = (i_req0 && i_req1) ? ~last_grant_q : i_req1;
                    grant_d      = win;
                    last_grant_d = win;
                    bus_we_d     = win ? i_we1    : i_we0;
                    bus_addr_d   = win ? i_addr1  : i_addr0;
                    bus_data_d   = win ? i_wdata1 : i_wdata0;
                    bus_clk_d    = 1'b1;
                    state_d      = BUSY;
`ifdef BUS_ARB_TIMEOUT_EN
                    cnt_d        = 16'd0;
`endif
                end
            end
            BUSY: begin
                if (i_bus_data_ready) begin
                    if (!bus_we_q) rdata_d = i_bus_data;
                    bus_clk_d = 1'b0;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    state_d   = ACK;
                end
`ifdef BUS_ARB_TIMEOUT_EN
                else if (expire) begin
                    if (!bus_we_q) rdata_d = '1;
                    err_d     = 1'b1;
                    bus_clk_d = 1'b0;
                    ack0_d    = ~grant_q;
                    ack1_d    = grant_q;
                    state_d   = ACK;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
`endif
            end
            ACK: begin
                state_d = IDLE;
`ifdef BUS_ARB_TIMEOUT_EN
                err_d   = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_cpu_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            grant_q      <= 1'b0;
            ack0_q       <= 1'b0;
            ack1_q       <= 1'b0;
            bus_clk_q    <= 1'b0;
            bus_we_q     <= 1'b0;
            bus_addr_q   <= '0;
            bus_data_q   <= '0;
            rdata_q      <= '0;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q        <= 16'd0;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= grant_d;
            ack0_q       <= ack0_d;
            ack1_q       <= ack1_d;
            bus_clk_q    <= bus_clk_d;
            bus_we_q     <= bus_we_d;
            bus_addr_q   <= bus_addr_d;
            bus_data_q   <= bus_data_d;
            rdata_q      <= rdata_d;
`ifdef BUS_ARB_TIMEOUT_EN
            cnt_q        <= cnt_d;
            err_q        <= err_d;
`endif
        end
    end

    assign o_ack0      = ack0_q;
    assign o_ack1      = ack1_q;
    assign o_rdata     = rdata_q;
    assign o_bus_clk   = bus_clk_q;
    assign o_bus_we    = bus_we_q;
    assign o_bus_addr  = bus_addr_q;
    assign o_bus_data  = bus_data_q;
    assign o_dbg_state = state_q;
`ifdef BUS_ARB_TIMEOUT_EN
    assign o_err       = err_q;
`else
    assign o_err       = 1'b0;
`endif

endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized accesses
// checked against a transaction-level model of grant order, latency and read data.
module tb_bus_arbiter;

    localparam int TP = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err, bus_clk, bus_we, bus_rdy;
    logic [31:0] rdata, bus_addr, bus_dout, bus_din;
    logic [1:0]  dbg_state;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    int          ack_cyc  = 0;
    int          prev_ack_cyc = 0;
    int          m_last;
    logic [31:0] m_rdata;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TP)) dut (
        .i_cpu_clk(clk), .i_rst(rst),
        .i_req0(req0), .i_req1(req1), .i_we0(we0), .i_we1(we1),
        .i_addr0(addr0), .i_addr1(addr1), .i_wdata0(wdata0), .i_wdata1(wdata1),
        .o_ack0(ack0), .o_ack1(ack1), .o_rdata(rdata), .o_err(err),
        .o_bus_clk(bus_clk), .o_bus_we(bus_we), .o_bus_addr(bus_addr),
        .o_bus_data(bus_dout), .i_bus_data(bus_din), .i_bus_data_ready(bus_rdy),
        .o_dbg_state(dbg_state)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One complete access: wait for the strobe, answer after dly BUSY cycles
    // (never, if the timeout must fire first), then check ack and read data.
    task automatic access(input int dly, input logic [31:0] rd, input bit drop);
        int          exp_port, busy, guard, exp_busy;
        bit          exp_to;
        logic        exp_we;
        logic [31:0] exp_addr, exp_wd;
        guard = 0;
        while (!bus_clk && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("strobe_rise", bus_clk, 1'b1);
        if (!bus_clk) return;
        exp_port = (req0 && req1) ? ((m_last == 1) ? 0 : 1) : (req0 ? 0 : 1);
        exp_we   = exp_port ? we1    : we0;
        exp_addr = exp_port ? addr1  : addr0;
        exp_wd   = exp_port ? wdata1 : wdata0;
        check("bus_we",   bus_we,   exp_we);
        check("bus_addr", bus_addr, exp_addr);
        check("bus_data", bus_dout, exp_wd);
        busy  = 0;
        guard = 0;
        do begin
            busy++;
            if (busy - 1 == dly) begin
                bus_rdy = 1'b1;
                bus_din = rd;
            end
            @(negedge clk);
            guard++;
        end while (!(ack0 || ack1) && guard < 300);
        bus_rdy = 1'b0;
        bus_din = $urandom;
`ifdef BUS_ARB_TIMEOUT_EN
        exp_to = (dly >= TP);
`else
        exp_to = 1'b0;
`endif
        exp_busy = exp_to ? TP : dly + 1;
        check("busy_cycles", busy, exp_busy);
        check("ack0", ack0, exp_port == 0);
        check("ack1", ack1, exp_port == 1);
        if (!exp_we) m_rdata = exp_to ? 32'hFFFF_FFFF : rd;
        check("rdata", rdata, m_rdata);
        check("err", err, exp_to);
        m_last       = exp_port;
        prev_ack_cyc = ack_cyc;
        ack_cyc      = cyc;
        if (drop) begin
            req0 = 1'b0;
            req1 = 1'b0;
        end else if (exp_port == 0) begin
            we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
        end else begin
            we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
        end
        @(negedge clk);
        check("ack_one_cycle", {ack0, ack1}, 2'b00);
    endtask

    initial begin
        int   guard, r;
        rst = 1'b1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0; bus_rdy = 0; bus_din = 0;
        m_last = 1; m_rdata = 32'h0;
        repeat (2) @(negedge clk);
        check("rst_ack",     {ack0, ack1}, 2'b00);
        check("rst_err",     err, 1'b0);
        check("rst_bus_clk", bus_clk, 1'b0);
        check("rst_bus_we",  bus_we, 1'b0);
        check("rst_addr",    bus_addr, 32'h0);
        check("rst_data",    bus_dout, 32'h0);
        check("rst_rdata",   rdata, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        // Port 0 read, ready one cycle after strobe.
        req0 = 1; we0 = 0; addr0 = 32'h0000_0200; wdata0 = $urandom;
        access(0, 32'hDEAD_BEEF, 1);

        // Port 1 write; read data must stay unchanged.
        req1 = 1; we1 = 1; addr1 = 32'h0000_D000; wdata1 = 32'h1234_5678;
        access(1, $urandom, 1);

        // Both ports requesting: strict alternation, one ack every 3 cycles.
        req0 = 1; req1 = 1;
        we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
        we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
        for (int i = 0; i < 8; i++) begin
            access(0, $urandom, 0);
            if (i > 0) check("b2b_spacing", ack_cyc - prev_ack_cyc, 3);
        end
        req0 = 0; req1 = 0;
        @(negedge clk);
        check("b2b_stopped", bus_clk, 1'b0);

`ifdef BUS_ARB_TIMEOUT_EN
        req0 = 1; we0 = 0; addr0 = $urandom; wdata0 = $urandom;
        access(TP + 5, $urandom, 1);
        req0 = 1; we0 = 0; addr0 = $urandom;
        access(TP - 1, 32'hCAFE_F00D, 1);
`endif

        // Reset in mid-BUSY abandons the access; the pending request is redone.
        req1 = 1; we1 = 0; addr1 = $urandom; wdata1 = $urandom;
        guard = 0;
        while (!bus_clk && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        check("rst_test_strobe", bus_clk, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("rst_mid_strobe", bus_clk, 1'b0);
        check("rst_mid_ack", {ack0, ack1}, 2'b00);
        @(negedge clk);
        check("rst_mid_ack_hold", {ack0, ack1}, 2'b00);
        rst = 1'b0;
        m_last = 1; m_rdata = 32'h0;
        access(1, $urandom, 1);

        // Randomized request mixes, directions and ready delays.
        for (int i = 0; i < 20; i++) begin
            r = $urandom_range(1, 3);
            req0 = r[0]; req1 = r[1];
            we0 = 1'($urandom); addr0 = $urandom; wdata0 = $urandom;
            we1 = 1'($urandom); addr1 = $urandom; wdata1 = $urandom;
            access($urandom_range(0, 3), $urandom, 1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
